// File: rtl/esc_pwm_decoder.sv
// ESC PWM receiver: measures the high time of one PWM line and recovers the speed code,
// flagging motors-off, saturated and malformed pulses, plus loss of signal.
`timescale 1ns/1ps
module esc_pwm_decoder #(
    parameter int        BASE_CLKS = 50000,
    parameter int        SCALE     = 3,
    parameter logic [9:0] OFF      = 10'h220,
    parameter int        MAX_HIGH  = 60000,
    parameter int        TIMEOUT   = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm,
    output logic [10:0] spd,
    output logic        spd_vld,
    output logic        mtr_off,
    output logic        sat,
    output logic        pls_err,
    output logic        lost
);

    localparam int              HW        = $clog2(MAX_HIGH + 2);
    localparam int              SW        = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [HW-1:0]   BASE_LAST = HW'(BASE_CLKS - 1);
    localparam logic [HW-1:0]   MAX_C     = HW'(MAX_HIGH);
    localparam logic [HW-1:0]   HSAT_C    = HW'(MAX_HIGH + 1);
    localparam logic [SW-1:0]   SUB_LAST  = SW'(SCALE - 1);
    localparam logic [19:0]     PRD_LAST  = 20'(TIMEOUT - 1);

    typedef enum logic [1:0] {ARM, IDLE, BASE, MEAS} state_t;

    state_t          state_r, state_s;
    logic            pwm_meta_r, pwm_sync_r, pwm_dly_r;
    logic            rise_s, fall_s;
    logic            err_s, done_s, pend_r;
    logic [HW-1:0]   hi_cnt_r;
    logic [SW-1:0]   sub_cnt_r;
    logic [11:0]     units_r;
    logic [19:0]     prd_cnt_r;
    logic [11:0]     dec_s;

    // Maps recovered units to {sat, spd}: below the idle offset reads as zero, above the code range clamps.
    function automatic logic [11:0] decode_units(input logic [11:0] units_v);
        logic [12:0] diff_v;
        logic [11:0] res_v;
        diff_v = {1'b0, units_v} - {3'b000, OFF};
        if (units_v < {2'b00, OFF}) begin
            res_v = 12'h000;
        end else if (diff_v > 13'd2047) begin
            res_v = {1'b1, 11'h7FF};
        end else begin
            res_v = {1'b0, diff_v[10:0]};
        end
        return res_v;
    endfunction

    assign rise_s = pwm_sync_r & ~pwm_dly_r;
    assign fall_s = ~pwm_sync_r & pwm_dly_r;
    assign dec_s  = decode_units(units_r);

    // Two-flop synchronizer plus delayed copy for edge detection; idles high so reset never fakes a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_meta_r <= 1'b1;
            pwm_sync_r <= 1'b1;
            pwm_dly_r  <= 1'b1;
        end else begin
            pwm_meta_r <= pwm;
            pwm_sync_r <= pwm_meta_r;
            pwm_dly_r  <= pwm_sync_r;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ARM;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic with the pulse-complete and pulse-error decisions.
    always_comb begin
        state_s = state_r;
        err_s   = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ARM: begin
                if (!pwm_sync_r) state_s = IDLE;
                else             state_s = ARM;
            end
            IDLE: begin
                if (rise_s) state_s = BASE;
                else        state_s = IDLE;
            end
            BASE: begin
                if (fall_s) begin
                    err_s   = 1'b1;
                    state_s = IDLE;
                end else if (pwm_sync_r && (hi_cnt_r == BASE_LAST)) begin
                    state_s = MEAS;
                end else begin
                    state_s = BASE;
                end
            end
            MEAS: begin
                if (fall_s) begin
                    state_s = IDLE;
                    if (hi_cnt_r > MAX_C) err_s = 1'b1;
                    else                  done_s = 1'b1;
                end else begin
                    state_s = MEAS;
                end
            end
            default: state_s = ARM;
        endcase
    end

    // High-time counters; the rise cycle itself is the first counted high cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_cnt_r  <= '0;
            sub_cnt_r <= '0;
            units_r   <= 12'h000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        hi_cnt_r  <= HW'(1);
                        sub_cnt_r <= '0;
                        units_r   <= 12'h000;
                    end
                end
                BASE: begin
                    if (pwm_sync_r && (hi_cnt_r < HSAT_C)) hi_cnt_r <= hi_cnt_r + HW'(1);
                end
                MEAS: begin
                    if (pwm_sync_r) begin
                        if (hi_cnt_r < HSAT_C) hi_cnt_r <= hi_cnt_r + HW'(1);
                        if (sub_cnt_r == SUB_LAST) begin
                            sub_cnt_r <= '0;
                            if (units_r != 12'hFFF) units_r <= units_r + 12'h001;
                        end else begin
                            sub_cnt_r <= sub_cnt_r + SW'(1);
                        end
                    end
                end
                default: begin
                    hi_cnt_r <= hi_cnt_r;
                end
            endcase
        end
    end

    // Decoded outputs are published one cycle after the fall so units is settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r  <= 1'b0;
            pls_err <= 1'b0;
            spd_vld <= 1'b0;
            spd     <= 11'h000;
            sat     <= 1'b0;
            mtr_off <= 1'b1;
        end else begin
            pend_r  <= done_s;
            pls_err <= err_s;
            spd_vld <= pend_r;
            if (pend_r) begin
                spd     <= dec_s[10:0];
                sat     <= dec_s[11];
                mtr_off <= (units_r == 12'h000);
            end
        end
    end

    // Loss-of-signal watchdog; a rise in the timeout cycle suppresses the set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prd_cnt_r <= 20'h00000;
            lost      <= 1'b0;
        end else begin
            if (rise_s) begin
                prd_cnt_r <= 20'h00000;
            end else if (prd_cnt_r != 20'hFFFFF) begin
                prd_cnt_r <= prd_cnt_r + 20'h00001;
            end
            if (!rise_s && (prd_cnt_r == PRD_LAST)) begin
                lost <= 1'b1;
            end else if (pend_r) begin
                lost <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_esc_pwm_decoder.sv
// Directed bench for esc_pwm_decoder with shortened timing parameters and a pulse scoreboard.
`timescale 1ns/1ps
module tb_esc_pwm_decoder;

    localparam int         BASE  = 200;
    localparam int         SCL   = 3;
    localparam logic [9:0] OFFV  = 10'h220;
    localparam int         MAXH  = 8100;
    localparam int         TOUT  = 12000;

    logic        clk, rst, pwm;
    logic [10:0] spd;
    logic        spd_vld, mtr_off, sat, pls_err, lost;

    typedef struct {
        logic [10:0] spd;
        logic        mtr;
        logic        sat;
        logic        err;
        logic        lost;
    } exp_t;

    exp_t        sb[$];
    int          applied = 0;
    int          miscompares = 0;
    int          vld_cnt = 0;
    int          err_cnt = 0;
    logic [10:0] m_spd = 11'h000;
    logic        m_mtr = 1'b1;
    logic        m_sat = 1'b0;
    logic        m_lost = 1'b0;

    esc_pwm_decoder #(
        .BASE_CLKS (BASE),
        .SCALE     (SCL),
        .OFF       (OFFV),
        .MAX_HIGH  (MAXH),
        .TIMEOUT   (TOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pwm     (pwm),
        .spd     (spd),
        .spd_vld (spd_vld),
        .mtr_off (mtr_off),
        .sat     (sat),
        .pls_err (pls_err),
        .lost    (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (spd_vld === 1'b1) vld_cnt++;
        if (pls_err === 1'b1) err_cnt++;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        applied++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input int high);
        exp_t e;
        int   u;
        e.spd = m_spd; e.mtr = m_mtr; e.sat = m_sat; e.err = 1'b0; e.lost = m_lost;
        if (high < BASE || high > MAXH) begin
            e.err = 1'b1;
        end else begin
            u = (high - BASE) / SCL;
            if (u > 4095) u = 4095;
            e.mtr  = (u == 0);
            e.lost = 1'b0;
            if (u < int'(OFFV)) begin
                e.spd = 11'h000; e.sat = 1'b0;
            end else if (u - int'(OFFV) > 2047) begin
                e.spd = 11'h7FF; e.sat = 1'b1;
            end else begin
                e.spd = 11'(u - int'(OFFV)); e.sat = 1'b0;
            end
        end
        return e;
    endfunction

    // Drive one pulse of exactly `high` clocks, then compare strobes, latency and outputs.
    task automatic pulse(input string tag, input int high, input int low);
        exp_t e;
        int   v0, e0, lat;
        e = model(high);
        sb.push_back(e);
        m_spd = e.spd; m_mtr = e.mtr; m_sat = e.sat; m_lost = e.lost;
        v0 = vld_cnt; e0 = err_cnt;
        @(posedge clk); #1 pwm = 1'b1;
        repeat (high) @(posedge clk);
        #1 pwm = 1'b0;
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (spd_vld === 1'b1 || pls_err === 1'b1) lat = c;
        end
        repeat (low) @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check({tag, "_lat"},  lat, e.err ? 3 : 4);
        check({tag, "_nvld"}, vld_cnt - v0, e.err ? 0 : 1);
        check({tag, "_nerr"}, err_cnt - e0, e.err ? 1 : 0);
        check({tag, "_spd"},  {21'd0, spd}, {21'd0, e.spd});
        check({tag, "_mtr"},  {31'd0, mtr_off}, {31'd0, e.mtr});
        check({tag, "_sat"},  {31'd0, sat}, {31'd0, e.sat});
        check({tag, "_lost"}, {31'd0, lost}, {31'd0, e.lost});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_spd"},  {21'd0, spd}, 32'h0);
        check({tag, "_vld"},  {31'd0, spd_vld}, 32'h0);
        check({tag, "_mtr"},  {31'd0, mtr_off}, 32'h1);
        check({tag, "_sat"},  {31'd0, sat}, 32'h0);
        check({tag, "_err"},  {31'd0, pls_err}, 32'h0);
        check({tag, "_lost"}, {31'd0, lost}, 32'h0);
    endtask

    initial begin
        int v0, e0, hi;
        logic [10:0] sp;
        rst = 1'b1;
        pwm = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("rst");

        // Line already high at reset release: that pulse must be ignored.
        rst = 1'b0;
        v0 = vld_cnt; e0 = err_cnt;
        repeat (300) @(posedge clk);
        #1 pwm = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("arm_nvld", vld_cnt - v0, 0);
        check("arm_nerr", err_cnt - e0, 0);
        check_reset_vals("arm");

        pulse("spd100",   BASE + SCL * (256 + 544), 300);
        pulse("mtroff",   BASE, 300);
        pulse("satur",    BASE + SCL * (544 + 2047 + 10), 300);
        pulse("short",    100, 300);
        pulse("base_m1",  BASE - 1, 300);
        pulse("atoff",    BASE + SCL * 544 + 2, 300);
        pulse("maxhigh",  MAXH, 300);
        pulse("too_long", MAXH + 1, 300);

        // Asynchronous reset in the middle of a measured pulse.
        @(posedge clk); #1 pwm = 1'b1;
        repeat (2400) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_vals("midrst");
        @(posedge clk); #1 rst = 1'b0;
        m_spd = 11'h000; m_mtr = 1'b1; m_sat = 1'b0; m_lost = 1'b0;
        v0 = vld_cnt; e0 = err_cnt;
        repeat (2000) @(posedge clk);
        #1 pwm = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("midrst_nvld", vld_cnt - v0, 0);
        check("midrst_nerr", err_cnt - e0, 0);
        check("midrst_spd", {21'd0, spd}, 32'h0);
        pulse("post_rst", BASE + SCL * (256 + 544), 300);

        // Generator-style stream: fixed period, motors_off alternating.
        for (int p = 0; p < 4; p++) begin
            sp = 11'h0A0 + 11'(p * 64);
            hi = (p % 2 == 1) ? BASE : BASE + SCL * (int'(sp) + int'(OFFV));
            pulse("gen", hi, 3500 - hi);
        end

        // Loss of signal, then recovery on one good pulse.
        repeat (TOUT + 50) @(posedge clk);
        @(negedge clk);
        m_lost = 1'b1;
        check("lost_set", {31'd0, lost}, 32'h1);
        check("lost_spd", {21'd0, spd}, {21'd0, m_spd});
        pulse("lost_clr", BASE + SCL * (256 + 544), 300);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
